// File: rtl/systolic_skew_feeder.sv
// -----------------------------------------------------------------------------
// systolic_skew_feeder
//
// Edge feeder placed directly upstream of the INT8 PE grid. One K-step
// wavefront (N row elements + N column elements) is taken per handshake and
// driven into the array with the diagonal skew the grid needs: lane i reaches
// the array edge i+1 advances after acceptance. Zero bubbles are injected on
// every advance that does not accept a wavefront, so partial sums inside the
// PEs are unaffected. After the last wavefront the feeder keeps advancing
// with zeros until the final product has reached PE[N-1][N-1], then pulses
// tile_done.
//
// Ports
//   clk         clock
//   rst         synchronous, active-high reset
//   arr_en      array advance enable; low freezes feeder and array
//   in_valid    wavefront on in_rows/in_cols is valid
//   in_ready    feeder can accept a wavefront this cycle (combinational)
//   in_last     marks the final wavefront of a tile
//   in_rows     row-lane data, lane i = [i*DATA_W +: DATA_W]
//   in_cols     column-lane data, same packing
//   west_rows   skewed row data to the west array edge
//   north_cols  skewed column data to the north array edge
//   row_vld     per-lane valid for west_rows
//   col_vld     per-lane valid for north_cols
//   busy        high while streaming or flushing a tile
//   tile_done   one-cycle pulse when the tile flush completes
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no tile in progress, ready for the first wavefront
// STREAM | tile open, accepting wavefronts, bubbles on in_valid=0
// FLUSH  | last wavefront taken, advancing zeros for 2N-1 advances
// DONE   | tile_done pulse, returns to IDLE on the next edge
// -----------------------------------------------------------------------------
module systolic_skew_feeder #(
  parameter int N      = 4,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arr_en,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_last,
  input  logic [N*DATA_W-1:0] in_rows,
  input  logic [N*DATA_W-1:0] in_cols,
  output logic [N*DATA_W-1:0] west_rows,
  output logic [N*DATA_W-1:0] north_cols,
  output logic [N-1:0]        row_vld,
  output logic [N-1:0]        col_vld,
  output logic                busy,
  output logic                tile_done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FLUSH  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Counter must hold 2N-1; $clog2(2N) bits is always enough (and >= 1).
  localparam int                CNT_W     = $clog2(2 * N);
  localparam logic [CNT_W-1:0]  FLUSH_CYC = CNT_W'(2 * N - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;

  assign in_ready  = arr_en & ((state_q == S_IDLE) | (state_q == S_STREAM));
  assign accept    = in_valid & in_ready;
  assign busy      = (state_q == S_STREAM) | (state_q == S_FLUSH);
  assign tile_done = (state_q == S_DONE);

  // ---------------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_STREAM: begin
        if (accept) begin
          if (in_last) begin
            state_d = S_FLUSH;
            cnt_d   = FLUSH_CYC;
          end else begin
            state_d = S_STREAM;
          end
        end
      end
      S_FLUSH: begin
        // Terminal count of 1 on an advance: that advance moves the final
        // product into PE[N-1][N-1].
        if (arr_en) begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        // Leaves DONE regardless of arr_en so the pulse is always one cycle.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Skew lanes: lane i is i+1 stages deep. Row and column lanes share the
  // same valid chain since they are loaded and shifted identically.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_W-1:0] row_sr [i+1];
    logic [DATA_W-1:0] col_sr [i+1];
    logic              vld_sr [i+1];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j <= i; j++) begin
          row_sr[j] <= '0;
          col_sr[j] <= '0;
          vld_sr[j] <= 1'b0;
        end
      end else if (arr_en) begin
        // Non-accepting advance injects a zero bubble.
        row_sr[0] <= accept ? in_rows[i*DATA_W +: DATA_W] : '0;
        col_sr[0] <= accept ? in_cols[i*DATA_W +: DATA_W] : '0;
        vld_sr[0] <= accept;
        for (int j = 1; j <= i; j++) begin
          row_sr[j] <= row_sr[j-1];
          col_sr[j] <= col_sr[j-1];
          vld_sr[j] <= vld_sr[j-1];
        end
      end
    end

    assign west_rows[i*DATA_W +: DATA_W]  = row_sr[i];
    assign north_cols[i*DATA_W +: DATA_W] = col_sr[i];
    assign row_vld[i]                     = vld_sr[i];
    assign col_vld[i]                     = vld_sr[i];
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_skew_feeder
//
// Self-checking bench for systolic_skew_feeder (N=4, DATA_W=16). The reference
// keeps a history of the last N wavefronts put onto the array (one entry per
// advance, newest first); lane i of the array edge is lane i of the wavefront
// injected i advances ago. Tile sequencing is tracked as tile phases with an
// advance count since the final wavefront.
// -----------------------------------------------------------------------------
module tb_systolic_skew_feeder;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int W  = N * DW;

  localparam int P_IDLE   = 0;
  localparam int P_STREAM = 1;
  localparam int P_FLUSH  = 2;
  localparam int P_DONE   = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         arr_en;
  logic         in_valid;
  logic         in_ready;
  logic         in_last;
  logic [W-1:0] in_rows;
  logic [W-1:0] in_cols;
  logic [W-1:0] west_rows;
  logic [W-1:0] north_cols;
  logic [N-1:0] row_vld;
  logic [N-1:0] col_vld;
  logic         busy;
  logic         tile_done;

  systolic_skew_feeder #(.N(N), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .arr_en     (arr_en),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .in_rows    (in_rows),
    .in_cols    (in_cols),
    .west_rows  (west_rows),
    .north_cols (north_cols),
    .row_vld    (row_vld),
    .col_vld    (col_vld),
    .busy       (busy),
    .tile_done  (tile_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // reference state
  logic [W-1:0] h_rows [N];
  logic [W-1:0] h_cols [N];
  logic         h_vld  [N];
  int           m_phase   = P_IDLE;
  int           m_fl_adv  = 0;
  bit           m_known   = 0;

  // scenario bookkeeping
  int cyc       = 0;
  int first_cyc = -1;
  int done_cyc  = -1;
  int busy_cnt  = 0;
  int vld2_cnt  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] pat(input int k, input int base);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(base + 16 * k + i);
    return v;
  endfunction

  task automatic step(input logic r, input logic en, input logic v, input logic l,
                      input logic [W-1:0] rows, input logic [W-1:0] cols);
    logic         exp_rdy, acc;
    int           prev;
    logic [W-1:0] e_rows, e_cols;
    logic [N-1:0] e_vld;

    @(negedge clk);
    rst = r; arr_en = en; in_valid = v; in_last = l; in_rows = rows; in_cols = cols;
    #1;
    exp_rdy = en && (m_phase == P_IDLE || m_phase == P_STREAM);
    if (m_known) check("in_ready", in_ready, exp_rdy);
    acc = v && exp_rdy;

    cyc++;
    if (r) begin
      for (int a = 0; a < N; a++) begin h_rows[a] = '0; h_cols[a] = '0; h_vld[a] = 0; end
      m_phase  = P_IDLE;
      m_fl_adv = 0;
      m_known  = 1;
    end else begin
      prev = m_phase;
      if (prev == P_DONE) m_phase = P_IDLE;
      if (en) begin
        for (int a = N - 1; a > 0; a--) begin
          h_rows[a] = h_rows[a-1]; h_cols[a] = h_cols[a-1]; h_vld[a] = h_vld[a-1];
        end
        h_rows[0] = acc ? rows : '0;
        h_cols[0] = acc ? cols : '0;
        h_vld[0]  = acc;
        if (acc && prev == P_IDLE) first_cyc = cyc;
        if (prev == P_IDLE || prev == P_STREAM) begin
          if (acc) begin
            m_phase  = l ? P_FLUSH : P_STREAM;
            m_fl_adv = 0;
          end
        end else if (prev == P_FLUSH) begin
          m_fl_adv++;
          if (m_fl_adv == 2 * N - 1) m_phase = P_DONE;
        end
      end
    end

    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      e_rows[i*DW +: DW] = h_rows[i][i*DW +: DW];
      e_cols[i*DW +: DW] = h_cols[i][i*DW +: DW];
      e_vld[i]           = h_vld[i];
    end
    if (m_known) begin
      check("west_rows",  west_rows,  e_rows);
      check("north_cols", north_cols, e_cols);
      check("row_vld",    row_vld,    e_vld);
      check("col_vld",    col_vld,    e_vld);
      check("busy",       busy,       (m_phase == P_STREAM || m_phase == P_FLUSH));
      check("tile_done",  tile_done,  (m_phase == P_DONE));
    end
    if (tile_done === 1'b1) done_cyc = cyc;
    if (busy === 1'b1) busy_cnt++;
    if (row_vld[2] === 1'b1) vld2_cnt++;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step(0, 1, 0, 0, '0, '0);
  endtask

  task automatic wave(input int k, input logic last);
    step(0, 1, 1, last, pat(k, 0), pat(k, 16'h0080));
  endtask

  task automatic basic_tile();
    vld2_cnt = 0;
    for (int k = 0; k < 4; k++) wave(k, k == 3);
    idle(10);
    check("lat_basic", 64'(done_cyc - first_cyc), 64'd10);
    check("vld2_cnt",  64'(vld2_cnt), 64'd4);
  endtask

  initial begin
    int saved_done;
    rst = 1; arr_en = 0; in_valid = 0; in_last = 0; in_rows = '0; in_cols = '0;

    // reset
    step(1, 1, 1, 0, pat(5, 0), pat(5, 0));
    step(1, 0, 1, 1, pat(6, 0), pat(6, 0));
    check("rst_west", west_rows, '0);
    check("rst_busy", busy, 1'b0);

    // back-to-back tile
    basic_tile();

    // two-cycle bubble in STREAM
    wave(0, 0); wave(1, 0);
    idle(2);
    wave(2, 0); wave(3, 1);
    idle(12);
    check("lat_gap", 64'(done_cyc - first_cyc), 64'd12);

    // arr_en low for three cycles mid-stream, in_valid held high
    wave(0, 0); wave(1, 0);
    for (int c = 0; c < 3; c++) step(0, 0, 1, 0, pat(9, 0), pat(9, 0));
    wave(2, 0); wave(3, 1);
    idle(12);
    check("lat_hold", 64'(done_cyc - first_cyc), 64'd13);

    // single-wavefront tile
    busy_cnt = 0;
    wave(7, 1);
    idle(10);
    check("single_busy", 64'(busy_cnt), 64'd7);
    check("lat_single",  64'(done_cyc - first_cyc), 64'd7);

    // reset during FLUSH with data in the lanes
    saved_done = done_cyc;
    for (int k = 0; k < 4; k++) wave(k, k == 3);
    idle(2);
    step(1, 1, 0, 0, '0, '0);
    check("rst_fl_vld", row_vld, '0);
    idle(12);
    check("rst_no_done", 64'(done_cyc), 64'(saved_done));
    basic_tile();

    // in_valid held high through FLUSH and DONE
    wave(0, 0); wave(1, 1);
    for (int c = 0; c < 10; c++) step(0, 1, 1, 0, pat(c + 2, 0), pat(c + 2, 16'h0080));
    check("next_accept", 64'(first_cyc - done_cyc), 64'd2);
    for (int c = 0; c < 3; c++) wave(c, c == 2);
    idle(12);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(299) == 0), ($urandom_range(7) != 0), $urandom_range(1),
           ($urandom_range(4) == 0), {$urandom, $urandom}, {$urandom, $urandom});
    end
    idle(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Edge feeder that sits directly upstream of the INT8 PE grid.
- Accepts one K-step wavefront per handshake: N row elements for the west edge and N column elements for the north edge.
- Applies the diagonal skew the array needs: lane i is delayed i extra cycles. It injects zero bubbles whenever no data is accepted, so accumulated sums stay unaffected.
- After the last wavefront it flushes the array and pulses tile_done when the final product has reached PE[N-1][N-1].

Parameters:
- N, 4, array dimension; number of row lanes and of column lanes.
- DATA_W, 16, per-lane element width; matches the PE edge ports.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- arr_en  in  1  array advance enable. Low = whole feeder and array hold.
- in_valid  in  1  wavefront on in_rows/in_cols is valid.
- in_ready  out  1  feeder can accept a wavefront this cycle.
- in_last  in  1  qualifies the final wavefront of a tile.
- in_rows  in  N*DATA_W  row-lane data; lane i = bits [i*DATA_W +: DATA_W].
- in_cols  in  N*DATA_W  column-lane data, same packing.
- west_rows  out  N*DATA_W  skewed row data to the west edge of the array.
- north_cols  out  N*DATA_W  skewed column data to the north edge of the array.
- row_vld  out  N  per-lane valid for west_rows.
- col_vld  out  N  per-lane valid for north_cols.
- busy  out  1  high in STREAM or FLUSH.
- tile_done  out  1  one-cycle pulse when the tile flush completes.

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- Reset (rst=1 at a clk edge):
  - All skew registers, west_rows, north_cols, row_vld, col_vld go to 0.
  - State = IDLE, flush counter = 0, tile_done = 0.
  - Reset dominates every other input.
  - Reset mid-tile discards all in-flight data; no tile_done is produced.
- Advance and accept:
  - An "advance" is any edge with arr_en=1.
  - accept = in_valid & in_ready.
  - in_ready = arr_en & (state==IDLE | state==STREAM); combinational.
- Skew pipeline:
  - Lane i is a shift register of depth i+1, updated only on advance.
  - On an advancing edge, stage 0 of every lane loads the input element if accept=1, else loads 0 with valid=0.
  - Lane i output = its last stage. An element accepted on advance t appears on lane i after exactly i+1 advances: lane 0 at t+1, lane N-1 at t+N.
  - Row and column lanes are skewed identically.
  - arr_en=0: all registers hold their value and valid; in_ready=0.
- FSM:
  - IDLE -> STREAM on accept with in_last=0.
  - IDLE -> FLUSH on accept with in_last=1 (single-wavefront tile).
  - STREAM -> FLUSH on accept with in_last=1.
  - STREAM stays in STREAM when in_valid=0; zero bubbles are injected and the tile is NOT terminated.
  - FLUSH: counter loads FLUSH_CYC = 2N-1 on entry. It decrements on each advance with zero injection. When the counter reaches 1 on an advance, next state = DONE.
  - DONE: tile_done=1 for exactly one cycle, then IDLE unconditionally (not gated by arr_en).
  - in_ready=0 in FLUSH and DONE.
- Latency: the last wavefront is accepted on advance t; tile_done is high in the cycle after advance t+2N-1.
- busy: 1 in STREAM and FLUSH, 0 in IDLE and DONE.
- N=1: FLUSH_CYC=1; the DONE pulse follows one advance after the in_last accept.
- Widths: no arithmetic on data; values pass bit-exact.

Test Plan:
- Reset, then N=4, arr_en=1, four back-to-back wavefronts with in_rows lane i = 0x10*k+i (k=0..3), in_last on k=3.
  - Required: west_rows lane 2 shows 0x02,0x12,0x22,0x32 starting 3 cycles after the first accept.
  - Required: row_vld[2] is high for exactly 4 cycles.
  - Required: tile_done pulses 7 cycles after the k=3 accept.
- Insert in_valid=0 for 2 cycles between k=1 and k=2.
  - Required: every lane shows a 2-cycle zero gap with vld=0.
  - Required: order is preserved and tile_done is delayed by 2 cycles.
- Drop arr_en for 3 cycles mid-stream.
  - Required: in_ready=0 and all outputs frozen for those cycles.
  - Required: the sequence resumes unchanged and tile_done is delayed by exactly 3 cycles.
- Single-wavefront tile (accept with in_last=1 from IDLE).
  - Required: busy=1 for 7 cycles, then tile_done for 1 cycle, then in_ready=1 again.
- Assert rst during FLUSH with data in the lanes.
  - Required: next cycle all outputs and vld are 0, state IDLE, no tile_done.
  - Required: a new tile afterwards behaves exactly as in the first scenario.
- Attempt in_valid=1 during FLUSH and DONE.
  - Required: in_ready=0 and no data accepted.
  - Required: the next tile is accepted the cycle after the tile_done pulse.
